// File: rtl/alu_pipe_pkg.sv
// Shared types for alu_pipe: opcode and FSM state encodings, flag bit positions.
package alu_pipe_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_NOT = 3'b011,
    OP_OR  = 3'b100,
    OP_XOR = 3'b101,
    OP_SHL = 3'b110,
    OP_MUL = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_V = 2;

endpackage

// File: rtl/alu_pipe_mul.sv
// Unsigned shift-add multiplier: one partial product per cycle, W cycles after start.
module alu_pipe_mul #(
  parameter int W = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic           done,
  output logic [2*W-1:0] product
);
  localparam int CW = $clog2(W);

  logic [2*W-1:0] r_mcand;
  logic [2*W-1:0] r_acc;
  logic [W-1:0]   r_mplier;
  logic [CW-1:0]  r_cnt;
  logic           r_active;
  logic [2*W-1:0] w_acc_next;

  assign w_acc_next = r_mplier[0] ? (r_acc + r_mcand) : r_acc;
  // done marks the cycle whose partial product completes the sum; product is valid then
  assign done    = r_active && (r_cnt == CW'(W - 1));
  assign product = w_acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand  <= '0;
      r_acc    <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (start) begin
      r_mcand  <= {{W{1'b0}}, a};
      r_acc    <= '0;
      r_mplier <= b;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + CW'(1);
      if (done) r_active <= 1'b0;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Handshaked ALU with registered result/flags; MUL is multi-cycle when ALU_PIPE_MUL_EN
// is defined, otherwise op 111 completes in one cycle with result 0.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result,
  output logic [2:0]   flags,
  output logic         busy
);
  localparam int SW = $clog2(W);

  state_e         r_state, w_state_next;
  logic [W-1:0]   r_result, w_res_next;
  logic [2:0]     r_flags, w_flags_next;
  logic           w_accept, w_load, w_is_mul;
  logic           w_mul_done;
  logic [2*W-1:0] w_mul_product;
  op_e            w_op;

  logic [W-1:0]   w_b_eff, w_sum, w_shl, w_alu_res;
  logic [W-2:0]   w_low;
  logic           w_cin, w_c_msb, w_cout, w_msb, w_alu_v;
  logic [SW-1:0]  w_shamt;

  function automatic logic [2:0] make_flags(input logic [W-1:0] r, input logic v);
    logic [2:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_N] = r[W-1];
    f[FLAG_V] = v;
    return f;
  endfunction

  assign w_op     = op_e'(op);
  assign w_accept = in_valid && (r_state == S_IDLE);

  // SUB is a + ~b + 1; split at the MSB so both carries are visible for V
  assign w_b_eff          = (w_op == OP_SUB) ? ~b : b;
  assign w_cin            = (w_op == OP_SUB);
  assign {w_c_msb, w_low} = {1'b0, a[W-2:0]} + {1'b0, w_b_eff[W-2:0]} + {{(W-1){1'b0}}, w_cin};
  assign {w_cout, w_msb}  = {1'b0, a[W-1]} + {1'b0, w_b_eff[W-1]} + {1'b0, w_c_msb};
  assign w_sum            = {w_msb, w_low};

  assign w_shamt = b[SW-1:0];
  assign w_shl   = (32'(w_shamt) >= W) ? '0 : (a << w_shamt);

  always_comb begin
    w_alu_res = '0;
    w_alu_v   = 1'b0;
    case (w_op)
      OP_ADD, OP_SUB: begin
        w_alu_res = w_sum;
        w_alu_v   = w_c_msb ^ w_cout;
      end
      OP_AND:  w_alu_res = a & b;
      OP_NOT:  w_alu_res = ~a;
      OP_OR:   w_alu_res = a | b;
      OP_XOR:  w_alu_res = a ^ b;
      OP_SHL:  w_alu_res = w_shl;
      default: w_alu_res = '0;
    endcase
  end

`ifdef ALU_PIPE_MUL_EN
  assign w_is_mul = (w_op == OP_MUL);

  alu_pipe_mul #(.W(W)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (w_accept && w_is_mul),
    .a       (a),
    .b       (b),
    .done    (w_mul_done),
    .product (w_mul_product)
  );

  assign busy = (r_state == S_BUSY);
`else
  assign w_is_mul      = 1'b0;
  assign w_mul_done    = 1'b0;
  assign w_mul_product = '0;
  assign busy          = 1'b0;
`endif

  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_res_next   = w_alu_res;
    w_flags_next = make_flags(w_alu_res, w_alu_v);
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_is_mul) begin
            w_state_next = S_BUSY;
          end else begin
            w_state_next = S_DONE;
            w_load       = 1'b1;
          end
        end
      end
      S_BUSY: begin
        if (w_mul_done) begin
          w_state_next = S_DONE;
          w_load       = 1'b1;
          w_res_next   = w_mul_product[W-1:0];
          w_flags_next = make_flags(w_mul_product[W-1:0], |w_mul_product[2*W-1:W]);
        end
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // result/flags move only when an operation completes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result <= '0;
      r_flags  <= '0;
    end else if (w_load) begin
      r_result <= w_res_next;
      r_flags  <= w_flags_next;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign result    = r_result;
  assign flags     = r_flags;

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (W=16); expectations follow ALU_PIPE_MUL_EN when defined.
module tb_alu_pipe;
  localparam int W = 16;
`ifdef ALU_PIPE_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic [2:0]  op = '0;
  logic        in_ready, out_valid, busy;
  logic [15:0] result;
  logic [2:0]  flags;

  int n_pass = 0;
  int n_total = 0;

  alu_pipe #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .op        (op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .flags     (flags),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Reference: returns {V,N,Z,result} from the arithmetic meaning of each opcode
  function automatic logic [18:0] model(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y);
    longint      s;
    logic [31:0] p;
    logic [15:0] r;
    logic        v;
    r = '0;
    v = 1'b0;
    case (o)
      3'd0: begin s = longint'($signed(x)) + longint'($signed(y)); r = s[15:0]; v = (s > 32767) || (s < -32768); end
      3'd1: begin s = longint'($signed(x)) - longint'($signed(y)); r = s[15:0]; v = (s > 32767) || (s < -32768); end
      3'd2: r = x & y;
      3'd3: r = ~x;
      3'd4: r = x | y;
      3'd5: r = x ^ y;
      3'd6: r = x << y[3:0];
      default: begin
        if (MUL_EN) begin
          p = {16'h0, x} * {16'h0, y};
          r = p[15:0];
          v = |p[31:16];
        end
      end
    endcase
    return {v, r[15], (r == 16'h0), r};
  endfunction

  task automatic xact(input logic [2:0] o, input logic [15:0] x, input logic [15:0] y,
                      output int lat, output logic [15:0] res, output logic [2:0] flg,
                      output int bcyc, output logic ov_after);
    @(negedge clk);
    op = o; a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    bcyc = 0;
    while (out_valid !== 1'b1 && lat < 100) begin
      if (busy === 1'b1) bcyc++;
      @(posedge clk); #1;
      lat++;
    end
    if (out_valid !== 1'b1) lat = -1;
    res = result;
    flg = flags;
    @(posedge clk); #1;
    ov_after = out_valid;
    $display("xact op=%0d a=%h b=%h -> result=%h flags=%b latency=%0d busy_cycles=%0d",
             o, x, y, res, flg, lat, bcyc);
  endtask

  task automatic test_reset();
    #1;
    n_total++; if ({out_valid, busy, in_ready} !== 3'b001) $display("FAIL reset_ctrl: got %b want 001", {out_valid, busy, in_ready}); else n_pass++;
    n_total++; if ({result, flags} !== 19'h0) $display("FAIL reset_data: got %h/%b want 0000/000", result, flags); else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_vectors();
    int lat, bc; logic [15:0] r; logic [2:0] f; logic ova;
    xact(3'd0, 16'h7FFF, 16'h0001, lat, r, f, bc, ova);
    n_total++; if (lat !== 1) $display("FAIL add_ovf_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if ({r, f} !== {16'h8000, 3'b110}) $display("FAIL add_ovf: got %h/%b want 8000/110", r, f); else n_pass++;
    n_total++; if (ova !== 1'b0) $display("FAIL add_ovf_pulse: out_valid after handshake got %b want 0", ova); else n_pass++;
    xact(3'd1, 16'h0005, 16'h0005, lat, r, f, bc, ova);
    n_total++; if ({r, f} !== {16'h0000, 3'b001}) $display("FAIL sub_zero: got %h/%b want 0000/001", r, f); else n_pass++;
    xact(3'd3, 16'h0000, 16'h1234, lat, r, f, bc, ova);
    n_total++; if ({r, f} !== {16'hFFFF, 3'b010}) $display("FAIL not_zero: got %h/%b want ffff/010", r, f); else n_pass++;
    xact(3'd6, 16'h0001, 16'h00FF, lat, r, f, bc, ova);
    n_total++; if ({r, f} !== {16'h8000, 3'b010}) $display("FAIL shl_15: got %h/%b want 8000/010", r, f); else n_pass++;
  endtask

  task automatic test_mul_mode();
    int lat, bc; logic [15:0] r; logic [2:0] f; logic ova;
`ifdef ALU_PIPE_MUL_EN
    xact(3'd7, 16'h0100, 16'h0100, lat, r, f, bc, ova);
    n_total++; if (lat !== 17) $display("FAIL mul_latency: got %0d want 17", lat); else n_pass++;
    n_total++; if (bc !== 16) $display("FAIL mul_busy_cycles: got %0d want 16", bc); else n_pass++;
    n_total++; if ({r, f} !== {16'h0000, 3'b101}) $display("FAIL mul_ovf: got %h/%b want 0000/101", r, f); else n_pass++;
    xact(3'd7, 16'h0003, 16'h0005, lat, r, f, bc, ova);
    n_total++; if ({r, f} !== {16'h000F, 3'b000}) $display("FAIL mul_3x5: got %h/%b want 000f/000", r, f); else n_pass++;
`else
    xact(3'd7, 16'h0003, 16'h0005, lat, r, f, bc, ova);
    n_total++; if (lat !== 1) $display("FAIL mul_off_latency: got %0d want 1", lat); else n_pass++;
    n_total++; if (bc !== 0) $display("FAIL mul_off_busy: got %0d want 0", bc); else n_pass++;
    n_total++; if ({r, f} !== {16'h0000, 3'b001}) $display("FAIL mul_off: got %h/%b want 0000/001", r, f); else n_pass++;
`endif
  endtask

  task automatic test_random();
    int lat, bc; logic [15:0] r; logic [2:0] f; logic ova;
    logic [15:0] edges [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0000};
    logic [2:0] o; logic [15:0] x, y; logic [18:0] exp; int exp_lat;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 7));
      x = 16'($urandom);
      y = 16'($urandom);
      if ($urandom_range(0, 3) == 0) x = edges[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) y = edges[$urandom_range(0, 3)];
      exp = model(o, x, y);
      exp_lat = (o == 3'd7 && MUL_EN) ? W + 1 : 1;
      xact(o, x, y, lat, r, f, bc, ova);
      n_total++; if ({f, r} !== exp) $display("FAIL rand_data[%0d] op=%0d a=%h b=%h: got %b/%h want %b/%h", i, o, x, y, f, r, exp[18:16], exp[15:0]); else n_pass++;
      n_total++; if (lat !== exp_lat) $display("FAIL rand_latency[%0d] op=%0d: got %0d want %0d", i, o, lat, exp_lat); else n_pass++;
      n_total++; if (bc !== exp_lat - 1) $display("FAIL rand_busy[%0d] op=%0d: got %0d want %0d", i, o, bc, exp_lat - 1); else n_pass++;
      n_total++; if (ova !== 1'b0) $display("FAIL rand_pulse[%0d]: out_valid after handshake got %b want 0", i, ova); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int extra;
    @(negedge clk);
    op = 3'd0; a = 16'h0001; b = 16'h0002; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      n_total++;
      if ({out_valid, in_ready, result, flags} !== {1'b1, 1'b0, 16'h0003, 3'b000})
        $display("FAIL hold[%0d]: got ov=%b ir=%b %h/%b want ov=1 ir=0 0003/000", i, out_valid, in_ready, result, flags);
      else n_pass++;
      @(negedge clk);
      in_valid = 1'b1; a = 16'($urandom); b = 16'($urandom); op = 3'($urandom_range(0, 6));
      @(posedge clk); #1;
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if ({out_valid, in_ready, result} !== {1'b0, 1'b1, 16'h0003}) $display("FAIL hold_release: got ov=%b ir=%b %h want ov=0 ir=1 0003", out_valid, in_ready, result); else n_pass++;
    extra = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) extra++;
    end
    n_total++; if (extra !== 0) $display("FAIL hold_single_transfer: extra out_valid cycles got %0d want 0", extra); else n_pass++;
    $display("xact backpressure ADD 1+2 held 5 cycles -> result=%h", result);
  endtask

  task automatic test_abort();
    int lat, bc, stale; logic [15:0] r; logic [2:0] f; logic ova;
    @(negedge clk);
    op = 3'd0; a = 16'h0009; b = 16'h0009; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_total++; if ({out_valid, result} !== {1'b1, 16'h0012}) $display("FAIL abort_done_pre: got ov=%b %h want ov=1 0012", out_valid, result); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_total++; if ({out_valid, busy, result, flags} !== 21'h0) $display("FAIL abort_done: got ov=%b busy=%b %h/%b want all 0", out_valid, busy, result, flags); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_total++; if ({out_valid, in_ready} !== 2'b01) $display("FAIL abort_done_post: got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready); else n_pass++;
    $display("xact reset during DONE");
`ifdef ALU_PIPE_MUL_EN
    xact(3'd0, 16'h0001, 16'h0001, lat, r, f, bc, ova);
    @(negedge clk);
    op = 3'd7; a = 16'h1234; b = 16'h5678; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #2;
    n_total++; if (busy !== 1'b1) $display("FAIL abort_busy_pre: busy got %b want 1", busy); else n_pass++;
    rst_n = 1'b0;
    #1;
    n_total++; if ({out_valid, busy, result, flags} !== 21'h0) $display("FAIL abort_busy: got ov=%b busy=%b %h/%b want all 0", out_valid, busy, result, flags); else n_pass++;
    @(negedge clk) rst_n = 1'b1;
    #1;
    n_total++; if (in_ready !== 1'b1) $display("FAIL abort_busy_ready: in_ready got %b want 1", in_ready); else n_pass++;
    stale = 0;
    repeat (20) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1 || busy === 1'b1) stale++;
    end
    n_total++; if (stale !== 0) $display("FAIL abort_busy_stale: stale cycles got %0d want 0", stale); else n_pass++;
    $display("xact reset during BUSY");
`endif
    xact(3'd0, 16'h0002, 16'h0002, lat, r, f, bc, ova);
    n_total++; if ({lat, r, f} !== {32'd1, 16'h0004, 3'b000}) $display("FAIL post_reset_add: got lat=%0d %h/%b want lat=1 0004/000", lat, r, f); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_mul_mode();
    test_backpressure();
    test_random();
    test_abort();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
